vga_line_prefetch: RTL and testbench

//   Ping-pong scanline buffer upstream of the VGA timing generator. While line N is displayed

---
 rtl/vga_line_prefetch_pkg.sv | 28 ++
 rtl/vga_line_prefetch_if.sv | 27 ++
 rtl/vga_line_prefetch_linebuf_ram.sv | 23 ++
 rtl/vga_line_prefetch.sv | 131 +++++++++++++
 tb/tb_vga_line_prefetch.sv | 209 ++++++++++++++++++++
 5 files changed

// File: rtl/vga_line_prefetch_pkg.sv
// Shared definitions for the VGA scanline prefetch buffer: display geometry per
// mode, the RGB565 pixel type and the fill FSM state encoding.
package vga_line_prefetch_pkg;

  localparam int LW = 11;

  localparam logic [LW-1:0] H_ACT_640  = 11'd640;
  localparam logic [LW-1:0] V_ACT_480  = 11'd480;
  localparam logic [LW-1:0] H_ACT_1024 = 11'd1024;
  localparam logic [LW-1:0] V_ACT_768  = 11'd768;

  typedef logic [15:0] rgb565_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_FILL,
    ST_DONE
  } fill_state_t;

  function automatic logic [LW-1:0] h_active(input logic mode);
    return mode ? H_ACT_1024 : H_ACT_640;
  endfunction

  function automatic logic [LW-1:0] v_active(input logic mode);
    return mode ? V_ACT_768 : V_ACT_480;
  endfunction

endpackage

// File: rtl/vga_line_prefetch_if.sv
// Upstream pixel stream feeding the line buffer: valid/ready data plus the
// line number being requested and a restart pulse for the source.
interface vga_line_prefetch_if;
  import vga_line_prefetch_pkg::*;

  rgb565_t       in_data;
  logic          in_valid;
  logic          in_ready;
  logic [LW-1:0] req_line;
  logic          req_start;

  modport master (
    output in_data,
    output in_valid,
    input  in_ready,
    input  req_line,
    input  req_start
  );

  modport slave (
    input  in_data,
    input  in_valid,
    output in_ready,
    output req_line,
    output req_start
  );
endinterface

// File: rtl/vga_line_prefetch_linebuf_ram.sv
// Simple dual-port line RAM: one write port, one registered read port with
// read enable (output holds when re is low). Address MSB selects the bank.
module vga_line_prefetch_linebuf_ram #(
  parameter int DATA_W = 16,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
    if (re) rdata <= mem[raddr];
  end

endmodule

// File: rtl/vga_line_prefetch.sv
// Ping-pong scanline buffer: displays one bank while the other is filled from the
// upstream stream. Optional test pattern output enabled by VGA_LINEBUF_PATTERN_EN.
module vga_line_prefetch
  import vga_line_prefetch_pkg::*;
#(
  parameter int      MAX_W       = 1024,
  parameter int      AW          = 10,
  parameter rgb565_t BLANK_COLOR = 16'h0
) (
  input  logic                vga_clk,
  input  logic                sys_rst_n,
  input  logic                vga_mode,
  input  logic                frame_start,
  input  logic                load_req,
  input  logic                rd_en,
`ifdef VGA_LINEBUF_PATTERN_EN
  input  logic                test_pat,
`endif
  output rgb565_t             pix_data,
  output logic                underrun,
  vga_line_prefetch_if.slave  up
);

  localparam logic [AW:0] RD_MAX = (AW+1)'(MAX_W-1);

  fill_state_t   state, state_nxt;
  logic          disp_bank, fill_bank;
  logic [AW:0]   wr_ptr, rd_ptr;
  logic [LW-1:0] line_w, line_h, filled, req_line_q;
  logic          req_start_q;
  logic          xfer;
  logic          vld_p1;
  rgb565_t       rd_q_p1;

  function automatic logic [AW:0] sat_inc(input logic [AW:0] p);
    return (p >= RD_MAX) ? RD_MAX : p + (AW+1)'(1);
  endfunction

  assign up.in_ready  = (state == ST_FILL) && !load_req && !frame_start;
  assign up.req_line  = req_line_q;
  assign up.req_start = req_start_q;
  assign xfer         = up.in_valid && up.in_ready;

  always_comb begin
    state_nxt = state;
    if (frame_start || load_req)
      state_nxt = ST_FILL;
    else if (state == ST_FILL && xfer && (LW'(wr_ptr) + 11'd1 == line_w))
      state_nxt = ST_DONE;
  end

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) begin
      state       <= ST_IDLE;
      disp_bank   <= 1'b0;
      fill_bank   <= 1'b1;
      wr_ptr      <= '0;
      rd_ptr      <= '0;
      line_w      <= H_ACT_640;
      line_h      <= V_ACT_480;
      filled      <= '0;
      req_line_q  <= '0;
      req_start_q <= 1'b0;
      underrun    <= 1'b0;
      vld_p1      <= 1'b0;
    end else begin
      state       <= state_nxt;
      req_start_q <= frame_start | load_req;
      if (xfer) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (rd_en) begin
        rd_ptr <= sat_inc(rd_ptr);
        vld_p1 <= (LW'(rd_ptr) < filled);
      end
      // Swap first; a coincident frame_start then overrides line number and fill.
      if (load_req) begin
        if (state != ST_DONE) begin
          underrun <= 1'b1;
          filled   <= LW'(wr_ptr);
        end else begin
          filled   <= line_w;
        end
        disp_bank  <= fill_bank;
        fill_bank  <= disp_bank;
        rd_ptr     <= '0;
        wr_ptr     <= '0;
        req_line_q <= (req_line_q == line_h - 11'd1) ? '0 : req_line_q + 11'd1;
      end
      if (frame_start) begin
        line_w     <= h_active(vga_mode);
        line_h     <= v_active(vga_mode);
        req_line_q <= '0;
        wr_ptr     <= '0;
      end
    end
  end

  vga_line_prefetch_linebuf_ram #(
    .DATA_W (16),
    .ADDR_W (AW+1)
  ) u_ram (
    .clk   (vga_clk),
    .we    (xfer),
    .waddr ({fill_bank, wr_ptr[AW-1:0]}),
    .wdata (up.in_data),
    .re    (rd_en),
    .raddr ({disp_bank, rd_ptr[AW-1:0]}),
    .rdata (rd_q_p1)
  );

`ifdef VGA_LINEBUF_PATTERN_EN
  logic [5:0] disp_line;
  logic       tp_p1;
  rgb565_t    pat_p1;

  always_ff @(posedge vga_clk) begin
    if (!sys_rst_n) tp_p1 <= 1'b0;
    else if (rd_en) tp_p1 <= test_pat;
  end

  // Pattern datapath: line tag follows the bank that becomes visible on swap.
  always_ff @(posedge vga_clk) begin
    if (load_req) disp_line <= req_line_q[7:2];
    if (rd_en)    pat_p1    <= {rd_ptr[7:3], disp_line, 5'h1F};
  end

  assign pix_data = tp_p1 ? pat_p1 : (vld_p1 ? rd_q_p1 : BLANK_COLOR);
`else
  assign pix_data = vld_p1 ? rd_q_p1 : BLANK_COLOR;
`endif

endmodule

// File: tb/tb_vga_line_prefetch.sv
// Directed bench for vga_line_prefetch: expected pixels are queued as reads are
// issued and popped when the registered output appears.
module tb_vga_line_prefetch;

  logic        vga_clk = 1'b0;
  logic        sys_rst_n = 1'b0;
  logic        vga_mode = 1'b0;
  logic        frame_start = 1'b0;
  logic        load_req = 1'b0;
  logic        rd_en = 1'b0;
  logic [15:0] pix_data;
  logic        underrun;
`ifdef VGA_LINEBUF_PATTERN_EN
  logic        test_pat = 1'b0;
`endif

  int n_cmp = 0;
  int n_err = 0;
  logic [15:0] exp_q[$];

  vga_line_prefetch_if up();

  vga_line_prefetch dut (
    .vga_clk     (vga_clk),
    .sys_rst_n   (sys_rst_n),
    .vga_mode    (vga_mode),
    .frame_start (frame_start),
    .load_req    (load_req),
    .rd_en       (rd_en),
`ifdef VGA_LINEBUF_PATTERN_EN
    .test_pat    (test_pat),
`endif
    .pix_data    (pix_data),
    .underrun    (underrun),
    .up          (up)
  );

  always #5 vga_clk = ~vga_clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout, required $finish before 1ms");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge vga_clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h required %0h", tag, obs, exp);
    end
  endtask

  task automatic pulse(input string tag, input bit fs, input bit lr);
    frame_start = fs;
    load_req    = lr;
    #1;
    check({tag, "_in_ready"}, 32'(up.in_ready), 32'd0);
    step();
    frame_start = 1'b0;
    load_req    = 1'b0;
    check({tag, "_req_start"}, 32'(up.req_start), 32'd1);
  endtask

  task automatic push_words(input string tag, input int n, input int base);
    int sent;
    int guard;
    bit xf;
    sent  = 0;
    guard = 0;
    up.in_valid = 1'b1;
    while (sent < n && guard < n + 200) begin
      up.in_data = 16'(base + sent);
      #1;
      xf = up.in_ready;
      step();
      if (xf) sent++;
      guard++;
    end
    up.in_valid = 1'b0;
    check({tag, "_words"}, 32'(sent), 32'(n));
  endtask

  task automatic read_one(input string tag, input logic [15:0] e);
    logic [15:0] got;
    exp_q.push_back(e);
    rd_en = 1'b1;
    step();
    got = exp_q.pop_front();
    check(tag, 32'(pix_data), 32'(got));
    rd_en = 1'b0;
  endtask

  task automatic read_check(input string tag, input int first, input int n,
                            input int base, input int valid_cnt);
    logic [15:0] e;
    for (int i = first; i < first + n; i++) begin
      exp_q.push_back((i < valid_cnt) ? 16'(base + i) : 16'h0);
      rd_en = 1'b1;
      step();
      e = exp_q.pop_front();
      check(tag, 32'(pix_data), 32'(e));
    end
    rd_en = 1'b0;
  endtask

  initial begin
    up.in_data  = '0;
    up.in_valid = 1'b0;

    // reset state
    step();
    step();
    check("rst_pix", 32'(pix_data), 32'd0);
    check("rst_in_ready", 32'(up.in_ready), 32'd0);
    check("rst_req_line", 32'(up.req_line), 32'd0);
    check("rst_req_start", 32'(up.req_start), 32'd0);
    check("rst_underrun", 32'(underrun), 32'd0);
    sys_rst_n = 1'b1;
    step();

    // full 640 line, swap, read back
    vga_mode = 1'b0;
    pulse("t1_fs", 1'b1, 1'b0);
    check("t1_req_line0", 32'(up.req_line), 32'd0);
    #1;
    check("t1_fill_ready", 32'(up.in_ready), 32'd1);
    push_words("t1", 640, 0);
    check("t1_done_ready", 32'(up.in_ready), 32'd0);
    pulse("t1_lr", 1'b0, 1'b1);
    check("t1_req_line1", 32'(up.req_line), 32'd1);
    check("t1_underrun", 32'(underrun), 32'd0);
    read_check("t1_pix", 0, 640, 0, 640);
    step();
    check("t1_hold", 32'(pix_data), 32'd639);
    read_check("t1_past_w", 640, 1, 0, 640);

    // stall in the middle of a fill
    push_words("t5a", 30, 2000);
    repeat (50) step();
    check("t5_stall_ready", 32'(up.in_ready), 32'd1);
    push_words("t5b", 610, 2030);
    check("t5_done_ready", 32'(up.in_ready), 32'd0);
    pulse("t5_lr", 1'b0, 1'b1);
    check("t5_req_line2", 32'(up.req_line), 32'd2);
    check("t5_underrun", 32'(underrun), 32'd0);
    read_check("t5_pix", 0, 640, 2000, 640);

    // load_req and frame_start together mid-fill
    push_words("t4", 50, 3000);
    pulse("t4_both", 1'b1, 1'b1);
    check("t4_req_line", 32'(up.req_line), 32'd0);
    check("t4_underrun", 32'(underrun), 32'd1);
    step();
    check("t4_start_pulse", 32'(up.req_start), 32'd0);
    read_check("t4_pix", 0, 640, 3000, 50);

    // reset for one clock mid-fill
    push_words("t6", 10, 7000);
    sys_rst_n = 1'b0;
    step();
    sys_rst_n = 1'b1;
    check("t6_pix", 32'(pix_data), 32'd0);
    check("t6_in_ready", 32'(up.in_ready), 32'd0);
    check("t6_req_line", 32'(up.req_line), 32'd0);
    check("t6_req_start", 32'(up.req_start), 32'd0);
    check("t6_underrun", 32'(underrun), 32'd0);
    up.in_valid = 1'b1;
    repeat (5) step();
    check("t6_idle_ready", 32'(up.in_ready), 32'd0);
    up.in_valid = 1'b0;
    read_check("t6_blank", 0, 4, 0, 0);

    // short fill -> underrun, partial line
    pulse("t2_fs", 1'b1, 1'b0);
    push_words("t2", 100, 1000);
    pulse("t2_lr", 1'b0, 1'b1);
    check("t2_underrun", 32'(underrun), 32'd1);
    check("t2_req_line", 32'(up.req_line), 32'd1);
    read_check("t2_pix", 0, 640, 1000, 100);

    // 1024x768: full lines, pointer saturation, line wrap
    vga_mode = 1'b1;
    pulse("t3_fs", 1'b1, 1'b0);
    vga_mode = 1'b0;
    for (int l = 0; l < 2; l++) begin
      push_words("t3", 1024, 5000 + 1000 * l);
      check("t3_done_ready", 32'(up.in_ready), 32'd0);
      pulse("t3_lr", 1'b0, 1'b1);
      check("t3_req_line", 32'(up.req_line), 32'(l + 1));
      read_check("t3_pix", 0, 1024, 5000 + 1000 * l, 1024);
      read_one("t3_sat", 16'(5000 + 1000 * l + 1023));
    end
    for (int k = 3; k <= 768; k++) begin
      pulse("t3_wrap", 1'b0, 1'b1);
      check("t3_wrap_line", 32'(up.req_line), 32'(k % 768));
    end
    check("t3_underrun_sticky", 32'(underrun), 32'd1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
